// File: rtl/sweep_pkg.sv
// sweep_pkg: shared FSM states, signature width, seed and MISR taps for truth_table_sweeper
package sweep_pkg;
    typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;
    localparam int SIG_W = 16;
    localparam logic [SIG_W-1:0] SIG_SEED = 16'hFFFF;
    localparam logic [SIG_W-1:0] SIG_TAPS = 16'hB400;
    function automatic logic [SIG_W-1:0] misr_next(input logic [SIG_W-1:0] s, input logic z);
        return {s[SIG_W-2:0], (^(s & SIG_TAPS)) ^ z};
    endfunction
endpackage

// File: rtl/sweep_hold_timer.sv
// sweep_hold_timer: counts 0..HOLD_CYCLES-1 while enabled; last flags the final hold cycle
module sweep_hold_timer #(
    parameter int HOLD_CYCLES = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic last
);
    localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    logic [CW-1:0] r_cnt;
    assign last = en && (r_cnt == CW'(HOLD_CYCLES - 1));
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_cnt <= '0;
        else if (clr || last) r_cnt <= '0;
        else if (en) r_cnt <= r_cnt + 1'b1;
    end
endmodule

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: exhaustive ascending sweep of a combinational DUT against EXP_TABLE;
// define SWEEP_SIGNATURE_EN to build the 16-bit MISR signature.
module truth_table_sweeper
    import sweep_pkg::*;
#(
    parameter int N_IN = 3,
    parameter int HOLD_CYCLES = 10,
    parameter logic [(1<<N_IN)-1:0] EXP_TABLE = 8'b1110_1000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [N_IN-1:0]  pattern,
    input  logic             z_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [N_IN:0]    err_count,
    output logic [N_IN-1:0]  first_fail_idx,
    output logic [SIG_W-1:0] signature
);
    localparam logic [N_IN:0] IDX_LAST = (N_IN+1)'((1 << N_IN) - 1);
    state_t r_state, w_state_nxt;
    logic [N_IN:0] r_idx, r_err, w_err_nxt;
    logic [N_IN-1:0] r_ffi;
    logic r_pass, w_go, w_last, w_sample, w_final, w_mis;
    sweep_hold_timer #(.HOLD_CYCLES(HOLD_CYCLES)) u_hold (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (w_go),
        .en   (busy),
        .last (w_last)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else r_state <= w_state_nxt;
    end
    always_comb begin
        w_go = (r_state == IDLE) && start;
        w_sample = (r_state == DRIVE) && w_last;
        w_final = w_sample && (r_idx == IDX_LAST);
        w_mis = w_sample && (z_in != EXP_TABLE[r_idx[N_IN-1:0]]);
        w_err_nxt = r_err + (N_IN+1)'(w_mis);
        w_state_nxt = w_go ? DRIVE : w_final ? DONE : (r_state == DONE) ? IDLE : r_state;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx  <= '0;
            r_err  <= '0;
            r_ffi  <= '0;
            r_pass <= 1'b0;
        end else if (w_go) begin
            r_idx  <= '0;
            r_err  <= '0;
            r_ffi  <= '0;
            r_pass <= 1'b0;
        end else if (w_sample) begin
            r_err <= w_err_nxt;
            if (w_mis && r_err == '0) r_ffi <= r_idx[N_IN-1:0];
            r_idx <= w_final ? '0 : r_idx + 1'b1;
            if (w_final) r_pass <= (w_err_nxt == '0);
        end
    end
    assign busy = (r_state == DRIVE);
    assign done = (r_state == DONE);
    assign pattern = r_idx[N_IN-1:0];
    assign pass = r_pass;
    assign err_count = r_err;
    assign first_fail_idx = r_ffi;
`ifdef SWEEP_SIGNATURE_EN
    logic [SIG_W-1:0] r_sig, r_sig_out;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sig     <= '0;
            r_sig_out <= '0;
        end else if (w_go) begin
            r_sig <= SIG_SEED;
        end else if (w_sample) begin
            r_sig <= misr_next(r_sig, z_in);
            if (w_final) r_sig_out <= misr_next(r_sig, z_in);
        end
    end
    assign signature = r_sig_out;
`else
    assign signature = '0;
`endif
endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
Parametrised, clocked successor to our exhaustive 3-input combinational sweep bench, built as synthesisable RTL.
- Drives all 2^N_IN input patterns, in ascending order, onto a combinational DUT.
- Holds each pattern for a programmable number of cycles and samples the DUT's single output.
- Compares each sample against a parameterised expected truth table and reports pass/fail, error count and first failing index.
- Sits beside the DUT on the board or in simulation; it replaces the hand-written stimulus loop.

Parameters:
- N_IN, 3, number of DUT inputs (1..8).
- HOLD_CYCLES, 10, cycles each pattern is held (>=1).
- EXP_TABLE, 8'b1110_1000, expected z per pattern index, width 2^N_IN; bit k is the expected z for pattern k.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a sweep.
- pattern  out  N_IN  stimulus to DUT; bit 0 maps to x0.
- z_in  in  1  DUT output.
- busy  out  1  high while sweeping.
- done  out  1  one-cycle pulse at sweep end.
- pass  out  1  high when the last sweep had zero errors.
- err_count  out  N_IN+1  number of mismatches in the last sweep.
- first_fail_idx  out  N_IN  lowest failing pattern index; valid only when err_count!=0.
- signature  out  16  MISR result; tied to 0 without SWEEP_SIGNATURE_EN.

Behaviour:
- Reset: asynchronous and active-low, as already decided. While rst_n=0, all outputs and state are 0 and the FSM is in IDLE.
- FSM states: IDLE, DRIVE, DONE.
- IDLE -> DRIVE: on start=1 at a clock edge.
  - Clears err_count and first_fail_idx.
  - Sets pass=0.
  - Loads the pattern index to 0 and the hold counter to 0.
- DRIVE:
  - busy=1 and pattern=current index.
  - The hold counter counts 0..HOLD_CYCLES-1.
  - In the last hold cycle, z_in is compared with EXP_TABLE[idx].
  - On mismatch, err_count increments. If it was 0, first_fail_idx is set to idx.
  - The index then advances and the hold counter resets.
- Index counter is N_IN+1 bits wide. Terminal is detected when idx==2^N_IN-1 and its sample completes; the index never wraps to 0 mid-sweep.
- DRIVE -> DONE after the final sample:
  - done=1 for exactly one cycle.
  - busy=0.
  - pass is registered as (final err_count==0), including the last sample's result.
  - pattern returns to 0.
- DONE -> IDLE the next cycle. pass, err_count and first_fail_idx are held until the next start.
- Latency: start at edge t0 gives busy=1 and pattern=0 from t0+1. A sweep takes 2^N_IN*HOLD_CYCLES drive cycles; done is asserted at t0 + 2^N_IN*HOLD_CYCLES + 1.
- start while busy or during DONE is ignored. start in IDLE is accepted even if it occurs in the same cycle DONE exits.
- rst_n asserted mid-sweep: everything clears immediately. No done pulse and no partial result is retained.
- err_count maximum is 2^N_IN, which fits in N_IN+1 bits, so no saturation is needed.

Optional Feature:
- Macro: SWEEP_SIGNATURE_EN.
- When defined:
  - A 16-bit Fibonacci MISR is seeded to 16'hFFFF on start.
  - On each sample it updates as sig <= {sig[14:0], sig[15]^sig[13]^sig[12]^sig[10]^z_in}.
  - signature is updated at done and held until the next start.
- When undefined: no MISR logic is built and signature is constant 0.

Decomposition:
- Package sweep_pkg holds:
  - the state enum (IDLE, DRIVE, DONE);
  - SIG_W=16;
  - SIG_SEED=16'hFFFF;
  - the MISR tap constants.
- One sub-module, sweep_hold_timer:
  - parameter HOLD_CYCLES;
  - inputs clk, rst_n, clr, en;
  - output last, asserted in the final hold cycle.

Test Plan:
1. Default params, DUT=majority(x2,x1,x0), start pulse at t0.
   - pattern steps 0..7, each held for 10 cycles.
   - done at t0+81; pass=1, err_count=0.
2. Default params, z_in stuck at 0.
   - err_count=4, first_fail_idx=3, pass=0.
3. Default params, start re-pulsed at t0+25.
   - Ignored: pattern=2 at t0+25, done still at t0+81.
4. rst_n low at t0+35.
   - Immediately pattern=0 and busy=0; no done pulse.
   - A subsequent start runs a full, clean sweep.
5. N_IN=4, HOLD_CYCLES=1, EXP_TABLE=16'h8000, DUT=4-input AND.
   - 16 patterns; done at t0+17; pass=1.
   - Index reaches 15 and does not wrap.
6. SWEEP_SIGNATURE_EN defined, test 1 run twice.
   - signature equals the bench MISR model value on both runs.
   - Flipping z at pattern 5 changes signature.
